// File: rtl/dvp_pkg.sv
// Shared types and defaults for the RAW8 Avalon-ST to DVP transmit path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VS,
    VBACK,
    ACTIVE,
    HBLANK
  } dvp_state_t;

  // Default 720p-style timing
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_BLANK  = 160;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_VS_LINES = 3;
  localparam int DEF_V_BACK   = 20;

  localparam int BYTES_PER_WORD = 8;

  // Width of the h/v position counters; wide enough for any practical timing
  localparam int CNT_W = 16;

endpackage

// File: rtl/dvp_word_unpacker.sv
// Two-entry word buffer (shifter + prefetch) that hands out one pixel byte per request.
// Latency: a requested byte is presented combinationally and consumed on the same edge.
// Backpressure: ready_data_ddr = !prefetch_full; words are accepted whenever the prefetch slot is free.
//
// Ports:
//   clk_sys, reset               clock, synchronous active-high reset (flushes both entries)
//   data_ddr/valid/ready         Avalon-ST style word input, byte 0 = data_ddr[7:0] first
//   pix_req                      a byte is due on this edge
//   pix_align                    the byte due sits on an 8-byte boundary of the line
//   pix_byte, pix_empty          byte for this request; pix_empty = nothing available
module dvp_word_unpacker
  import dvp_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [63:0] data_ddr,
  input  logic        valid_data_ddr,
  output logic        ready_data_ddr,
  input  logic        pix_req,
  input  logic        pix_align,
  output logic [7:0]  pix_byte,
  output logic        pix_empty
);

  localparam logic [3:0] WORD_BYTES = 4'(BYTES_PER_WORD);

  logic [63:0] shifter, shifter_nxt;
  logic [63:0] prefetch;
  logic        prefetch_full;
  logic [3:0]  byte_cnt, byte_cnt_nxt;
  logic        take_prefetch;
  logic        accept;

  assign ready_data_ddr = !prefetch_full;
  assign accept         = valid_data_ddr && ready_data_ddr;

  // With the shifter drained, a waiting word is only started on a word
  // boundary of the line so pixels stay at their packed positions after an
  // underflow. In that case the byte comes straight from the prefetch slot.
  assign pix_empty = (byte_cnt == '0) && !(prefetch_full && pix_align);
  assign pix_byte  = (byte_cnt == '0) ? prefetch[7:0] : shifter[7:0];

  always_comb begin
    shifter_nxt   = shifter;
    byte_cnt_nxt  = byte_cnt;
    take_prefetch = 1'b0;
    if (pix_req && (byte_cnt != '0)) begin
      if ((byte_cnt == 4'd1) && prefetch_full) begin
        // last byte of this word leaves now; next word follows without a bubble
        shifter_nxt   = prefetch;
        byte_cnt_nxt  = WORD_BYTES;
        take_prefetch = 1'b1;
      end else begin
        shifter_nxt  = shifter >> 8;
        byte_cnt_nxt = byte_cnt - 4'd1;
      end
    end else if ((byte_cnt == '0) && prefetch_full && (!pix_req || pix_align)) begin
      take_prefetch = 1'b1;
      if (pix_req) begin
        shifter_nxt  = prefetch >> 8;
        byte_cnt_nxt = WORD_BYTES - 4'd1;
      end else begin
        shifter_nxt  = prefetch;
        byte_cnt_nxt = WORD_BYTES;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      shifter       <= '0;
      byte_cnt      <= '0;
      prefetch      <= '0;
      prefetch_full <= 1'b0;
    end else begin
      shifter  <= shifter_nxt;
      byte_cnt <= byte_cnt_nxt;
      if (accept) begin
        prefetch      <= data_ddr;
        prefetch_full <= 1'b1;
      end else if (take_prefetch) begin
        prefetch_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/avl_stream2dvp_raw.sv
// Unpacks 64-bit RAW8 words to bytes and regenerates DVP VSYNC/HREF/D timing with SOF/EOF.
// Latency: all outputs registered; first byte appears V_BACK+VS_LINES line periods after start_frame.
// Backpressure: none downstream; upstream stalls via ready_data_ddr, starvation gives D=0 and sticky underflow.
//
// Ports:
//   clk_sys, reset                    clock, synchronous active-high reset
//   start_frame                       launch one frame (honoured in IDLE only)
//   data_ddr/valid_data_ddr/ready_data_ddr   packed pixel word input
//   VSYNC, HREF, D, SOF, EOF          DVP-style output timing and frame markers
//   busy, underflow                   frame in progress; sticky starvation flag
module avl_stream2dvp_raw
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int VS_LINES = DEF_VS_LINES,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start_frame,
  input  logic [63:0] data_ddr,
  input  logic        valid_data_ddr,
  output logic        ready_data_ddr,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  D,
  output logic        SOF,
  output logic        EOF,
  output logic        busy,
  output logic        underflow
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACTIVE + H_BLANK - 1);
  localparam logic [CNT_W-1:0] HA_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VA_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(VS_LINES - 1);
  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(V_BACK - 1);

  dvp_state_t       state, state_nxt;
  logic [CNT_W-1:0] h_cnt, h_nxt, h_inc;
  logic [CNT_W-1:0] v_cnt, v_nxt;
  logic             h_wrap;
  logic             pix_req, pix_align, pix_empty;
  logic [7:0]       pix_byte;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // v_cnt restarts at each VS/VBACK/active-region transition; ACTIVE and
  // HBLANK together form one line, so the active line count spans both.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    h_wrap    = (h_cnt == H_LAST);
    h_inc     = h_wrap ? '0 : h_cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (start_frame) begin
          state_nxt = VS;
          h_nxt     = '0;
          v_nxt     = '0;
        end
      end
      VS: begin
        h_nxt = h_inc;
        if (h_wrap) begin
          if (v_cnt == VS_LAST) begin
            state_nxt = VBACK;
            v_nxt     = '0;
          end else begin
            v_nxt = v_cnt + 1'b1;
          end
        end
      end
      VBACK: begin
        h_nxt = h_inc;
        if (h_wrap) begin
          if (v_cnt == VB_LAST) begin
            state_nxt = ACTIVE;
            v_nxt     = '0;
          end else begin
            v_nxt = v_cnt + 1'b1;
          end
        end
      end
      ACTIVE: begin
        h_nxt = h_inc;
        if (h_cnt == HA_LAST) begin
          state_nxt = HBLANK;
        end
      end
      HBLANK: begin
        h_nxt = h_inc;
        if (h_wrap) begin
          if (v_cnt == VA_LAST) begin
            state_nxt = IDLE;
            v_nxt     = '0;
          end else begin
            state_nxt = ACTIVE;
            v_nxt     = v_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        h_nxt     = '0;
        v_nxt     = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with state.
  assign pix_req   = (state_nxt == ACTIVE);
  assign pix_align = (h_nxt[2:0] == 3'd0);

  dvp_word_unpacker u_unpacker (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .data_ddr       (data_ddr),
    .valid_data_ddr (valid_data_ddr),
    .ready_data_ddr (ready_data_ddr),
    .pix_req        (pix_req),
    .pix_align      (pix_align),
    .pix_byte       (pix_byte),
    .pix_empty      (pix_empty)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      VSYNC     <= 1'b0;
      HREF      <= 1'b0;
      D         <= '0;
      SOF       <= 1'b0;
      EOF       <= 1'b0;
      busy      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      VSYNC <= (state_nxt == VS);
      HREF  <= pix_req;
      D     <= (pix_req && !pix_empty) ? pix_byte : 8'h00;
      SOF   <= pix_req && (v_nxt == '0) && (h_nxt == '0);
      EOF   <= pix_req && (v_nxt == VA_LAST) && (h_nxt == HA_LAST);
      busy  <= (state_nxt != IDLE);
      if ((state == IDLE) && start_frame) begin
        underflow <= 1'b0;
      end else if (pix_req && pix_empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avl_stream2dvp_raw.sv
module tb_avl_stream2dvp_raw;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        start_frame = 1'b0;
  logic [63:0] data_ddr = '0;
  logic        valid_data_ddr = 1'b0;
  logic        ready_data_ddr;
  logic        VSYNC, HREF, SOF, EOF, busy, underflow;
  logic [7:0]  D;

  always #5 clk_sys = ~clk_sys;

  avl_stream2dvp_raw #(
    .H_ACTIVE (16),
    .H_BLANK  (4),
    .V_ACTIVE (2),
    .VS_LINES (1),
    .V_BACK   (1)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .start_frame    (start_frame),
    .data_ddr       (data_ddr),
    .valid_data_ddr (valid_data_ddr),
    .ready_data_ddr (ready_data_ddr),
    .VSYNC          (VSYNC),
    .HREF           (HREF),
    .D              (D),
    .SOF            (SOF),
    .EOF            (EOF),
    .busy           (busy),
    .underflow      (underflow)
  );

  // Checkpoint n = clocks after the edge that accepted start_frame.
  typedef struct {
    int         n;
    logic       vs;
    logic       hr;
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       bsy;
  } vec_t;

  vec_t       tbl[$];
  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         word_idx = 0;
  bit         feed_en = 1'b0;
  bit         feed_rand = 1'b0;
  int         low_run = 0;
  logic [7:0] got[$];
  logic [7:0] exp_b[$];
  int         sof_pos, eof_pos, frame_len;

  function automatic logic [63:0] mkword(input int i);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'((8 * i + b) & 255);
    return w;
  endfunction

  task automatic add(input int n, input logic vs, input logic hr, input logic [7:0] d,
                     input logic sof, input logic eof, input logic bsy);
    vec_t v;
    v.n = n; v.vs = vs; v.hr = hr; v.d = d; v.sof = sof; v.eof = eof; v.bsy = bsy;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
    vec_cnt++;
    if (got_v !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", name, got_v, exp_v);
    end
  endtask

  task automatic feed();
    bit v;
    if (!feed_en) v = 1'b0;
    else if (feed_rand) v = ($urandom_range(0, 1) == 1) || (low_run >= 3);
    else v = 1'b1;
    low_run = v ? 0 : low_run + 1;
    valid_data_ddr = v;
    data_ddr = mkword(word_idx);
  endtask

  // One clock: drive word input, let the edge happen, return at the negedge.
  task automatic cycle();
    bit hs;
    feed();
    hs = valid_data_ddr && ready_data_ddr && !reset;
    @(posedge clk_sys);
    @(negedge clk_sys);
    if (reset) word_idx = 0;
    else if (hs) word_idx++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic run_frame(input bit use_table, input int mid_start_n, input int feed_on_n);
    got.delete();
    sof_pos = -1; eof_pos = -1; frame_len = -1;
    start_frame = 1'b1;
    cycle();
    start_frame = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (use_table) begin
        foreach (tbl[i]) begin
          if (tbl[i].n == n)
            check($sformatf("vec_n%0d", n), {VSYNC, HREF, D, SOF, EOF, busy},
                  {tbl[i].vs, tbl[i].hr, tbl[i].d, tbl[i].sof, tbl[i].eof, tbl[i].bsy});
        end
      end
      if (HREF) begin
        if (SOF) sof_pos = got.size();
        if (EOF) eof_pos = got.size();
        got.push_back(D);
      end
      if (!busy) begin
        frame_len = n;
        break;
      end
      if (n == feed_on_n) feed_en = 1'b1;
      if (n == mid_start_n) start_frame = 1'b1;
      cycle();
      start_frame = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_len"}, frame_len, 80);
    check({tag, "_sof"}, sof_pos, 0);
    check({tag, "_eof"}, eof_pos, 31);
    check({tag, "_nbytes"}, got.size(), exp_b.size());
    for (int i = 0; i < got.size() && i < exp_b.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got[i], exp_b[i]);
  endtask

  task automatic exp_ramp(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) exp_b.push_back(8'((base + i) & 255));
  endtask

  initial begin
    // Timing checkpoints for the small frame: VS 0..19, VBACK 20..39,
    // line 0 at 40..55, HBLANK 56..59, line 1 at 60..75, HBLANK 76..79, idle at 80.
    add(0,  1, 0, 8'h00, 0, 0, 1);
    add(19, 1, 0, 8'h00, 0, 0, 1);
    add(20, 0, 0, 8'h00, 0, 0, 1);
    add(39, 0, 0, 8'h00, 0, 0, 1);
    add(40, 0, 1, 8'h00, 1, 0, 1);
    add(41, 0, 1, 8'h01, 0, 0, 1);
    add(47, 0, 1, 8'h07, 0, 0, 1);
    add(48, 0, 1, 8'h08, 0, 0, 1);
    add(55, 0, 1, 8'h0F, 0, 0, 1);
    add(56, 0, 0, 8'h00, 0, 0, 1);
    add(59, 0, 0, 8'h00, 0, 0, 1);
    add(60, 0, 1, 8'h10, 0, 0, 1);
    add(68, 0, 1, 8'h18, 0, 0, 1);
    add(75, 0, 1, 8'h1F, 0, 1, 1);
    add(76, 0, 0, 8'h00, 0, 0, 1);
    add(79, 0, 0, 8'h00, 0, 0, 1);
    add(80, 0, 0, 8'h00, 0, 0, 0);

    // Reset state, no stimulus
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    check("rst_ready", ready_data_ddr, 1);
    check("rst_outs", {VSYNC, HREF, D, SOF, EOF, busy, underflow}, 0);
    repeat (5) cycle();
    check("idle_outs", {VSYNC, HREF, D, SOF, EOF, busy, underflow}, 0);

    // Nominal frame, data always valid
    feed_en = 1'b1;
    repeat (4) cycle();
    run_frame(1'b1, -1, -1);
    exp_b.delete(); exp_ramp(0, 32);
    check_frame("nom");
    check("nom_underflow", underflow, 0);

    // Starved until line 0, h_cnt = 5
    feed_en = 1'b0;
    do_reset();
    run_frame(1'b0, -1, 45);
    exp_b.delete();
    for (int i = 0; i < 8; i++) exp_b.push_back(8'h00);
    exp_ramp(0, 24);
    check_frame("ufl");
    check("ufl_set", underflow, 1);
    repeat (10) cycle();
    check("ufl_sticky", underflow, 1);

    // New frame clears underflow and continues with the next word
    run_frame(1'b0, -1, -1);
    exp_b.delete(); exp_ramp(8'h18, 32);
    check_frame("clr");
    check("clr_underflow", underflow, 0);

    // Random valid backpressure plus an ignored start_frame mid-ACTIVE
    do_reset();
    feed_en = 1'b1;
    feed_rand = 1'b1;
    repeat (30) cycle();
    run_frame(1'b0, 44, -1);
    exp_b.delete(); exp_ramp(0, 32);
    check_frame("rnd");
    check("rnd_underflow", underflow, 0);
    repeat (20) cycle();
    check("rnd_words", word_idx, 6);
    check("rnd_ready", ready_data_ddr, 0);
    check("rnd_busy", busy, 0);
    feed_rand = 1'b0;

    // Reset during active line 1, then a clean frame
    do_reset();
    start_frame = 1'b1;
    cycle();
    start_frame = 1'b0;
    repeat (64) cycle();
    check("mid_href", {HREF, D}, {1'b1, 8'h14});
    reset = 1'b1;
    cycle();
    check("mid_rst_outs", {VSYNC, HREF, D, SOF, EOF, busy}, 0);
    check("mid_rst_ready", ready_data_ddr, 1);
    reset = 1'b0;
    repeat (2) cycle();
    run_frame(1'b1, -1, -1);
    exp_b.delete(); exp_ramp(0, 32);
    check_frame("post");
    check("post_underflow", underflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/avl_stream2dvp_raw.md
Name: avl_stream2dvp_raw

Overview:
- Transmit-side counterpart of the DVP-to-Avalon-ST RAW capture path.
- Accepts 64-bit RAW8 words read back from DDR (8 pixels per word) and unpacks them to one byte per clock.
- Regenerates DVP-style timing (VSYNC, HREF, 8-bit data) plus SOF/EOF markers.
- Feeds downstream video output and loopback test of the capture chain.

Parameters:
- H_ACTIVE, 1280: active pixels per line; must be a multiple of 8.
- H_BLANK, 160: HREF-low clocks after each active line.
- V_ACTIVE, 720: active lines per frame.
- VS_LINES, 3: line periods with VSYNC high.
- V_BACK, 20: blank line periods between VSYNC fall and first active line.

Ports:
- clk_sys  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start_frame  in  1  one-cycle pulse that launches one frame; honoured only in IDLE.
- data_ddr  in  64  packed pixels; byte 0 = data_ddr[7:0] is sent first.
- valid_data_ddr  in  1  data_ddr valid.
- ready_data_ddr  out  1  block accepts a word this cycle (valid & ready = transfer).
- VSYNC  out  1  frame sync, active high.
- HREF  out  1  line valid, active high.
- D  out  8  pixel byte; 0 when HREF is low.
- SOF  out  1  high with the first byte of a frame.
- EOF  out  1  high with the last byte of a frame.
- busy  out  1  frame in progress (state != IDLE).
- underflow  out  1  sticky; a byte was due but no word was available; cleared by an accepted start_frame.

Behaviour:
- Reset: all outputs 0 except ready_data_ddr = 1. FSM goes to IDLE, counters to 0, holding buffer empty.
- All outputs are registered. VSYNC, HREF, D, SOF and EOF change on the same edge.
- FSM states:
  - IDLE: waits for start_frame. start_frame in any other state is ignored.
  - VS: VSYNC = 1 for VS_LINES × (H_ACTIVE + H_BLANK) clocks.
  - VBACK: VSYNC = 0 for V_BACK line periods.
  - ACTIVE: HREF = 1 for H_ACTIVE clocks.
  - HBLANK: H_BLANK clocks, then ACTIVE while the line count is below V_ACTIVE; otherwise IDLE.
- Counters:
  - h_cnt counts 0..H_ACTIVE+H_BLANK-1 within each line period and wraps to 0.
  - v_cnt counts lines within a state and is reset on each state change.
- Buffering:
  - Two-entry word buffer: a shifter being unpacked plus one prefetch register.
  - ready_data_ddr = !prefetch_full. Words are accepted in any state, including IDLE, so the first line is prefetched during VBACK.
- Unpacking:
  - Each ACTIVE clock outputs shifter[7:0] and shifts right by 8.
  - After the 8th byte, the prefetch word moves into the shifter in the same cycle, so there is no bubble.
  - A simultaneous accept and move is legal.
- Underflow:
  - In ACTIVE with the shifter empty: D = 0, underflow set.
  - The byte position still advances; timing is never stretched.
  - The next arriving word aligns to the next 8-byte boundary of h_cnt.
- Markers:
  - SOF = 1 at h_cnt = 0 of active line 0.
  - EOF = 1 at h_cnt = H_ACTIVE-1 of line V_ACTIVE-1.
- Reset mid-frame: immediate return to IDLE, buffer flushed, outputs 0 on the next clock.

Decomposition:
- Shared package dvp_pkg: the FSM state enum (IDLE, VS, VBACK, ACTIVE, HBLANK), the default timing constants, and BYTES_PER_WORD = 8.
- One natural sub-module, dvp_word_unpacker: two-entry buffer, shifter and ready/valid logic. It takes a byte-request strobe and returns a byte plus an empty flag.
- The FSM and counters live in the top module.

Test Plan:
- Reset release with no stimulus -> all outputs 0, ready_data_ddr = 1, busy = 0.
- start_frame with small params (H_ACTIVE = 16, H_BLANK = 4, V_ACTIVE = 2, VS_LINES = 1, V_BACK = 1) and words 0x0706050403020100, 0x0F0E0D0C0B0A0908, ... always valid:
  - VSYNC high for 20 clocks, then 20 blank clocks.
  - HREF carries bytes 0x00..0x0F then 0x10..0x1F, with 4-clock gaps.
  - SOF on byte 0x00, EOF on byte 0x1F; underflow stays 0.
- Same frame with valid_data_ddr held low until active line 0, h_cnt = 5 -> D = 0 for bytes 0..7 and underflow = 1. Bytes 8..15 come from the first word (0x00..0x07); HREF timing is unchanged.
- Random valid_data_ddr backpressure with a 50% duty cycle, supplied well ahead of need -> pixel stream matches the packed input in order, underflow = 0, no word dropped or duplicated.
- start_frame pulsed mid-ACTIVE -> ignored, frame length unchanged. A second start_frame after returning to IDLE -> new frame and underflow cleared.
- reset asserted during the ACTIVE of line 1 -> next clock HREF = 0, VSYNC = 0, busy = 0; a following frame starts clean from fresh data.
